// File: rtl/fir_coef_ctrl.sv
// Coefficient configuration controller for fir: collects T serial tap weights
// into a shadow bank and swaps the whole bank onto W at a COMMIT_EN boundary.
module fir_coef_ctrl #(
    parameter int T  = 4,
    parameter int NI = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CFG_VALID,
    output logic                 CFG_READY,
    input  logic [NI-1:0]        CFG_DATA,
    input  logic                 CFG_LAST,
    input  logic                 COMMIT_EN,
    output logic [T-1:0][NI-1:0] W,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    input  logic                 ERR_CLR
);

    localparam int IW = $clog2(T);
    localparam logic [IW-1:0] LAST_IDX = IW'(T - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_COMMIT,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IW-1:0]         idx;
    logic [T-1:0][NI-1:0]  shadow;
    logic                  accept;
    logic                  err_set;
    logic                  commit;

    assign accept = CFG_VALID & CFG_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_nxt = state;
        err_set   = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (CFG_LAST) err_set   = 1'b1;
                    else          state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        if (CFG_LAST) begin
                            state_nxt = WAIT_COMMIT;
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (CFG_LAST) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_COMMIT: begin
                if (COMMIT_EN) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (accept && CFG_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx       <= '0;
            // NOTE: the shadow bank is reset so a later commit can never expose stale data.
            shadow    <= '0;
            W         <= '0;
            CFG_READY <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            CFG_READY <= (state_nxt != WAIT_COMMIT);
            DONE      <= commit;

            if (accept && state_nxt == LOAD) idx <= idx + 1'b1;
            else if (state_nxt != LOAD)      idx <= '0;

            // idx is 0 whenever IDLE, so one write path serves both states.
            if (accept && (state == IDLE || state == LOAD)) shadow[idx] <= CFG_DATA;

            if (commit) W <= shadow;

            if (err_set)      ERR <= 1'b1;
            else if (ERR_CLR) ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl (T=4, NI=8): reset, normal/delayed commit,
// short and long framing errors, reset mid-load with valid stalls.
module tb_fir_coef_ctrl;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            CFG_VALID;
    logic            CFG_READY;
    logic [7:0]      CFG_DATA;
    logic            CFG_LAST;
    logic            COMMIT_EN;
    logic [3:0][7:0] W;
    logic            BUSY;
    logic            DONE;
    logic            ERR;
    logic            ERR_CLR;

    int n_checks = 0;
    int n_fail   = 0;

    fir_coef_ctrl #(.T(4), .NI(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_DATA  (CFG_DATA),
        .CFG_LAST  (CFG_LAST),
        .COMMIT_EN (COMMIT_EN),
        .W         (W),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .ERR_CLR   (ERR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic beat(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge CLK);
        CFG_VALID = 1'b1;
        CFG_DATA  = d;
        CFG_LAST  = last;
        while (CFG_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) check("beat_accept_timeout", 32'(n), 32'd0);
        @(posedge CLK);
        #1;
        CFG_VALID = 1'b0;
        CFG_LAST  = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge CLK);
    endtask

    initial begin
        RST_N     = 1'b0;
        CFG_VALID = 1'b0;
        CFG_DATA  = '0;
        CFG_LAST  = 1'b0;
        COMMIT_EN = 1'b0;
        ERR_CLR   = 1'b0;

        // Reset state, then READY rises on the first edge after release
        #12;
        check("rst_w",     32'(W),         32'h0);
        check("rst_ready", 32'(CFG_READY), 32'h0);
        check("rst_busy",  32'(BUSY),      32'h0);
        check("rst_done",  32'(DONE),      32'h0);
        check("rst_err",   32'(ERR),       32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rel_ready_pre", 32'(CFG_READY), 32'h0);
        @(posedge CLK);
        #1;
        check("rel_ready_post", 32'(CFG_READY), 32'h1);

        // Normal load, COMMIT_EN held high: swap on the edge after LAST
        COMMIT_EN = 1'b1;
        beat(8'hFE, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b1);
        check("norm_wait_w",     32'(W),         32'h0);
        check("norm_wait_busy",  32'(BUSY),      32'h1);
        check("norm_wait_ready", 32'(CFG_READY), 32'h0);
        check("norm_wait_done",  32'(DONE),      32'h0);
        @(posedge CLK);
        #1;
        check("norm_w",     32'(W),         32'h0403FFFE);
        check("norm_done",  32'(DONE),      32'h1);
        check("norm_ready", 32'(CFG_READY), 32'h1);
        check("norm_busy",  32'(BUSY),      32'h0);
        @(posedge CLK);
        #1;
        check("norm_done_drop", 32'(DONE), 32'h0);

        // Delayed commit: W holds the previous set until COMMIT_EN rises
        COMMIT_EN = 1'b0;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b1);
        repeat (10) @(posedge CLK);
        #1;
        check("dly_w_hold", 32'(W),         32'h0403FFFE);
        check("dly_busy",   32'(BUSY),      32'h1);
        check("dly_ready",  32'(CFG_READY), 32'h0);
        check("dly_done",   32'(DONE),      32'h0);
        @(negedge CLK);
        COMMIT_EN = 1'b1;
        @(posedge CLK);
        #1;
        check("dly_w_swap", 32'(W),    32'h44332211);
        check("dly_done_p", 32'(DONE), 32'h1);
        COMMIT_EN = 1'b0;

        // Short set: LAST on beat 2 -> ERR, W untouched, back in IDLE
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b1);
        check("short_err",   32'(ERR),       32'h1);
        check("short_w",     32'(W),         32'h44332211);
        check("short_busy",  32'(BUSY),      32'h0);
        check("short_ready", 32'(CFG_READY), 32'h1);
        COMMIT_EN = 1'b1;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b1);
        @(posedge CLK);
        #1;
        COMMIT_EN = 1'b0;
        check("short_reload_w", 32'(W),   32'h04030201);
        check("short_err_sticky", 32'(ERR), 32'h1);
        @(negedge CLK);
        ERR_CLR = 1'b1;
        @(posedge CLK);
        #1;
        ERR_CLR = 1'b0;
        check("errclr", 32'(ERR), 32'h0);

        // Long set: ERR at beat 4, beats 5-6 drained, W untouched
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b0);
        check("long_err_pre", 32'(ERR), 32'h0);
        beat(8'hA4, 1'b0);
        check("long_err",   32'(ERR),       32'h1);
        check("long_drain", 32'(BUSY),      32'h1);
        check("long_ready", 32'(CFG_READY), 32'h1);
        beat(8'hA5, 1'b0);
        beat(8'hA6, 1'b1);
        check("long_idle", 32'(BUSY), 32'h0);
        check("long_w",    32'(W),    32'h04030201);

        // Reset mid-load with stalls: everything returns to reset values at once
        gap();
        beat(8'h77, 1'b0);
        gap();
        beat(8'h88, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_w",     32'(W),         32'h0);
        check("mid_rst_ready", 32'(CFG_READY), 32'h0);
        check("mid_rst_busy",  32'(BUSY),      32'h0);
        check("mid_rst_done",  32'(DONE),      32'h0);
        check("mid_rst_err",   32'(ERR),       32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rel_ready", 32'(CFG_READY), 32'h1);
        COMMIT_EN = 1'b1;
        gap();
        beat(8'h10, 1'b0);
        gap();
        beat(8'h20, 1'b0);
        gap();
        beat(8'h30, 1'b0);
        gap();
        beat(8'h40, 1'b1);
        check("post_rst_w_hold", 32'(W), 32'h0);
        @(posedge CLK);
        #1;
        check("post_rst_w",    32'(W),    32'h40302010);
        check("post_rst_done", 32'(DONE), 32'h1);
        check("post_rst_err",  32'(ERR),  32'h0);
        COMMIT_EN = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_coef_ctrl.md
# fir_coef_ctrl

Coefficient configuration controller for the `fir` filter. It accepts a serial stream of `T` tap weights over a valid/ready handshake into a shadow bank. It then commits the whole bank atomically to the active `W` bus feeding `fir`, at a sample boundary marked by `COMMIT_EN`. This prevents the filter from ever seeing a partially updated coefficient set.

## Interface
- `T`, default 4: number of taps (≥2).
- `NI`, default 8: coefficient width in bits, two's complement, passed through unaltered.

- `CLK` in 1: rising-edge clock shared with `fir`.
- `RST_N` in 1: asynchronous, active-low reset.
- `CFG_VALID` in 1: coefficient beat valid.
- `CFG_READY` out 1: controller can accept a beat (registered).
- `CFG_DATA` in NI: coefficient value. First beat of a set goes to tap 0.
- `CFG_LAST` in 1: marks the final beat of a set.
- `COMMIT_EN` in 1: sample-boundary strobe. A swap is allowed only on edges where this is high.
- `W` out [T-1:0][NI-1:0]: active coefficients, connected to `fir.W`.
- `BUSY` out 1: high when state ≠ IDLE.
- `DONE` out 1: one-cycle pulse after a successful commit.
- `ERR` out 1: sticky framing-error flag.
- `ERR_CLR` in 1: synchronous clear for `ERR`.

## Operation
- **Beat acceptance:** a beat is accepted on a rising edge with `CFG_VALID & CFG_READY`. `idx` (0..T-1) counts accepted beats of the current set.
- **States:** IDLE, LOAD, WAIT_COMMIT, DRAIN.
- **IDLE:** a beat writes `shadow[0]` and sets `idx=1`.
  - `CFG_LAST=1` on this beat → ERR set, go to IDLE.
  - Otherwise → LOAD.
- **LOAD:** a beat writes `shadow[idx]`.
  - `idx==T-1` with LAST → WAIT_COMMIT.
  - `idx<T-1` with LAST → ERR set, go to IDLE. Shadow is discarded and `W` is untouched.
  - `idx==T-1` without LAST → ERR set, go to DRAIN.
  - Otherwise `idx++`.
- **DRAIN:** accepts and discards beats until a beat with LAST, then goes to IDLE. `W` and shadow are not used.
- **WAIT_COMMIT:** `CFG_READY=0`. On an edge with `COMMIT_EN=1`: `W <= shadow` (all taps at once), `DONE` goes high for the next cycle, go to IDLE, `idx=0`.
- **`CFG_READY` next value:** 1 iff next state ∈ {IDLE, LOAD, DRAIN}.
- **`W` outside commits:** holds its value except on a commit edge.
- **`ERR_CLR`:** clears `ERR` on the edge. If an error is detected on the same edge, set wins.
- **Stalls:** `CFG_VALID` gaps of any length are legal in LOAD and DRAIN. No timeout.

## Timing
- **Reset values (while `RST_N` low, applied immediately):** `W`=0 on all taps, state IDLE, `idx`=0, shadow=0, `CFG_READY`=0, `BUSY`=0, `DONE`=0, `ERR`=0.
- **After reset release:** `CFG_READY` rises on the first rising edge.
- **Reset mid-load or mid-wait:** aborts immediately to reset values. No partial commit.
- **Last beat:** `CFG_READY` is low in the cycle after the LAST beat is accepted.
- **Commit latency:** the earliest commit is the edge after LAST acceptance. `COMMIT_EN` coinciding with the LAST beat has no effect.
- **After a commit:** `W` changes right after the commit edge, and `DONE` is high for exactly that following cycle.
- **Earliest next set:** `CFG_READY` is high in the cycle after the commit edge, so a new set can start 1 cycle after commit.
- **Throughput:** minimum T+1 cycles per set.
- **`BUSY`:** combinational from state.

## Test plan
1. **Reset check:** assert `RST_N=0` with `W` previously nonzero → `W`=0 with no clock edge, all outputs 0. Release → `CFG_READY`=1 after 1 edge.
2. **Normal load:** T=4, NI=8. Load 0xFE, 0xFF, 0x03, 0x04 with LAST on beat 4 and `COMMIT_EN`=1 → `W[0..3]`={0xFE,0xFF,0x03,0x04} one edge after beat 4. `DONE` pulses once. `CFG_READY` is back high.
3. **Delayed commit:** same load with `COMMIT_EN`=0 for 10 cycles after LAST → `W` keeps the previous set, `BUSY`=1, `CFG_READY`=0. Raise `COMMIT_EN` → swap on that edge.
4. **Short set:** LAST on beat 2 → `ERR`=1, `W` unchanged, state IDLE. A following full 4-beat load commits correctly. `ERR_CLR` then drops `ERR`.
5. **Long set:** 6 beats with LAST on beat 6 → `ERR` set at beat 4, beats 5–6 accepted and discarded, `W` unchanged, IDLE afterward.
6. **Reset mid-load plus stalls:** random `CFG_VALID` gaps during the load, then async reset after 2 beats → immediate return to reset values. A later full load commits correctly.
